// File: rtl/seq_adder_n.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock over a registered
// carry, with a Start/Busy/Done handshake and registered R/Co/Ovf/Zero.
module seq_adder_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic             Ci,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] R,
  output logic             Co,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CS = CHUNK + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   ch_sum;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] sum_full;
  logic             msb_cin;
  logic             last;

  // Datapath for the chunk selected by the counter
  always_comb begin
    shamt      = 32'(cnt_q) * CHUNK;
    a_ch       = CHUNK'(opa_q >> shamt);
    b_ch       = CHUNK'(opb_q >> shamt);
    ch_sum     = CS'(a_ch) + CS'(b_ch) + CS'(carry_q);
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    sum_full   = (psum_q & ~chunk_mask) | (WIDTH'(ch_sum[CHUNK-1:0]) << shamt);
    // carry into the chunk MSB recovered from its sum bit
    msb_cin    = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];
    last       = (cnt_q == CW'(N - 1));
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          opa_d   = A;
          opb_d   = Sub ? ~B : B;
          carry_d = Sub | Ci;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        psum_d  = sum_full;
        carry_d = ch_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          r_d     = sum_full;
          co_d    = ch_sum[CHUNK];
          ovf_d   = msb_cin ^ ch_sum[CHUNK];
          zero_d  = (sum_full == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign R    = r_q;
  assign Co   = co_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_seq_adder_n.sv
// Bench for seq_adder_n: 16/4 and 8/1 instances checked each cycle against an
// arithmetic model, plus directed operations with hand-computed results.
module tb_seq_adder_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        st16, sub16, ci16;
  logic [15:0] a16, b16, r16;
  logic        busy16, done16, co16, ovf16, zero16;

  logic        st8, sub8, ci8;
  logic [7:0]  a8, b8, r8;
  logic        busy8, done8, co8, ovf8, zero8;

  seq_adder_n #(.WIDTH(16), .CHUNK(4)) dut16 (
    .CLK(clk), .Reset_n(rst_n), .Start(st16), .Sub(sub16), .Ci(ci16),
    .A(a16), .B(b16), .Busy(busy16), .Done(done16), .R(r16),
    .Co(co16), .Ovf(ovf16), .Zero(zero16)
  );

  seq_adder_n #(.WIDTH(8), .CHUNK(1)) dut8 (
    .CLK(clk), .Reset_n(rst_n), .Start(st8), .Sub(sub8), .Ci(ci8),
    .A(a8), .B(b8), .Busy(busy8), .Done(done8), .R(r8),
    .Co(co8), .Ovf(ovf8), .Zero(zero8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain modular arithmetic: returns {ovf, co, r}
  function automatic logic [33:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic ci, input int w);
    logic [31:0] mask, am, bp, r;
    logic [32:0] s;
    logic        co, ovf;
    mask = (32'h1 << w) - 32'h1;
    am   = a & mask;
    bp   = sub ? (~b & mask) : (b & mask);
    s    = {1'b0, am} + {1'b0, bp} + {32'h0, (sub | ci)};
    r    = s[31:0] & mask;
    co   = s[w];
    ovf  = (am[w-1] == bp[w-1]) && (r[w-1] != am[w-1]);
    return {ovf, co, r};
  endfunction

  // Transaction-level model of both instances
  logic        m16_busy = 0, m16_done = 0, m16_co = 0, m16_ovf = 0, m16_zero = 0;
  logic [15:0] m16_r = '0;
  int          m16_left = 0;
  logic [33:0] p16 = '0;
  logic        m8_busy = 0, m8_done = 0, m8_co = 0, m8_ovf = 0, m8_zero = 0;
  logic [7:0]  m8_r = '0;
  int          m8_left = 0;
  logic [33:0] p8 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16_busy <= 0; m16_done <= 0; m16_co <= 0; m16_ovf <= 0; m16_zero <= 0;
      m16_r <= '0; m16_left <= 0; p16 <= '0;
    end else begin
      m16_done <= 0;
      if (m16_busy) begin
        m16_left <= m16_left - 1;
        if (m16_left == 1) begin
          m16_busy <= 0; m16_done <= 1;
          m16_r <= p16[15:0]; m16_co <= p16[32]; m16_ovf <= p16[33];
          m16_zero <= (p16[15:0] == 16'h0);
        end
      end else if (st16) begin
        p16 <= calc(32'(a16), 32'(b16), sub16, ci16, 16);
        m16_busy <= 1; m16_left <= 4;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_busy <= 0; m8_done <= 0; m8_co <= 0; m8_ovf <= 0; m8_zero <= 0;
      m8_r <= '0; m8_left <= 0; p8 <= '0;
    end else begin
      m8_done <= 0;
      if (m8_busy) begin
        m8_left <= m8_left - 1;
        if (m8_left == 1) begin
          m8_busy <= 0; m8_done <= 1;
          m8_r <= p8[7:0]; m8_co <= p8[32]; m8_ovf <= p8[33];
          m8_zero <= (p8[7:0] == 8'h0);
        end
      end else if (st8) begin
        p8 <= calc(32'(a8), 32'(b8), sub8, ci8, 8);
        m8_busy <= 1; m8_left <= 8;
      end
    end
  end

  always @(negedge clk) begin
    check("busy16", 32'(busy16), 32'(m16_busy));
    check("done16", 32'(done16), 32'(m16_done));
    check("r16",    32'(r16),    32'(m16_r));
    check("co16",   32'(co16),   32'(m16_co));
    check("ovf16",  32'(ovf16),  32'(m16_ovf));
    check("zero16", 32'(zero16), 32'(m16_zero));
    check("busy8",  32'(busy8),  32'(m8_busy));
    check("done8",  32'(done8),  32'(m8_done));
    check("r8",     32'(r8),     32'(m8_r));
    check("co8",    32'(co8),    32'(m8_co));
    check("ovf8",   32'(ovf8),   32'(m8_ovf));
    check("zero8",  32'(zero8),  32'(m8_zero));
  end

  // Issue one operation from a negedge and return at the negedge Done is seen
  task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic ci, input logic [15:0] er,
                        input logic eco, input logic eovf, input logic ez, input bit poke);
    int lat;
    int n;
    logic [15:0] rr, ee;
    n = sel ? 8 : 4;
    if (sel) begin st8 = 1; a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; ci8 = ci; end
    else     begin st16 = 1; a16 = a; b16 = b; sub16 = sub; ci16 = ci; end
    @(posedge clk);
    #1;
    st16 = 0; st8 = 0;
    if (sel) begin a8 = 8'h3C; b8 = 8'hC3; sub8 = ~sub; ci8 = ~ci; end
    else     begin a16 = 16'hDEAD; b16 = 16'hBEEF; sub16 = ~sub; ci16 = ~ci; end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (poke && lat == 2) begin st16 = 1; a16 = 16'h1111; end
      else if (poke) st16 = 0;
      @(negedge clk);
      if ((sel ? done8 : done16) === 1'b1) break;
    end
    check("latency", lat, n);
    rr = sel ? {8'h00, r8} : r16;
    ee = sel ? {8'h00, er[7:0]} : er;
    check("R_lit",    32'(rr), 32'(ee));
    check("Co_lit",   32'(sel ? co8 : co16),     32'(eco));
    check("Ovf_lit",  32'(sel ? ovf8 : ovf16),   32'(eovf));
    check("Zero_lit", 32'(sel ? zero8 : zero16), 32'(ez));
  endtask

  initial begin
    int seen;
    st16 = 0; sub16 = 0; ci16 = 0; a16 = '0; b16 = '0;
    st8 = 0; sub8 = 0; ci8 = 0; a8 = '0; b8 = '0;
    rst_n = 1;
    #1 rst_n = 0;
    @(negedge clk);
    check("rst_busy", 32'(busy16), 32'h0);
    check("rst_done", 32'(done16), 32'h0);
    check("rst_r",    32'(r16),    32'h0);
    check("rst_zero", 32'(zero16), 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    run_op(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0);
    run_op(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1, 0);
    run_op(0, 16'hFFFF, 16'h0001, 0, 1, 16'h0001, 1, 0, 0, 0);
    run_op(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0, 0);
    run_op(0, 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, 0, 0);
    run_op(0, 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    // Start pulsed mid-operation with A=0x1111 must be dropped
    run_op(0, 16'h1234, 16'h0101, 0, 0, 16'h1335, 0, 0, 0, 1);
    // Issued in the Done cycle of the previous operation
    run_op(0, 16'h0002, 16'h0003, 0, 0, 16'h0005, 0, 0, 0, 0);

    // Abort mid-RUN with reset
    repeat (2) @(negedge clk);
    st16 = 1; a16 = 16'h4321; b16 = 16'h1111; sub16 = 0; ci16 = 0;
    @(posedge clk);
    #1 st16 = 0;
    @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy16), 32'h1);
    rst_n = 0;
    #1;
    check("abort_busy", 32'(busy16), 32'h0);
    check("abort_done", 32'(done16), 32'h0);
    check("abort_r",    32'(r16),    32'h0);
    check("abort_co",   32'(co16),   32'h0);
    check("abort_ovf",  32'(ovf16),  32'h0);
    check("abort_zero", 32'(zero16), 32'h0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done16 === 1'b1) seen++;
    end
    check("no_done_after_abort", seen, 0);

    run_op(1, 16'h00AA, 16'h0055, 0, 1, 16'h0000, 1, 0, 1, 0);
    run_op(1, 16'h007F, 16'h0080, 1, 0, 16'h00FF, 0, 1, 0, 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
